// File: rtl/edgedet_multi.sv
// Multi-channel synchronising edge detector with per-channel mode, sticky pending/overflow flags.
// Optional debounce filter enabled by defining EDGEDET_DEBOUNCE_EN.
module edgedet_multi #(
    parameter int unsigned NUM_CHANNELS    = 8,
    parameter int unsigned SYNC_STEPS      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [NUM_CHANNELS-1:0]   in_signal,
    input  logic [2*NUM_CHANNELS-1:0] in_mode,
    input  logic [NUM_CHANNELS-1:0]   in_ack,
    output logic [NUM_CHANNELS-1:0]   out_edge,
    output logic [NUM_CHANNELS-1:0]   out_pending,
    output logic [NUM_CHANNELS-1:0]   out_overflow,
    output logic                      out_any
);

`ifdef EDGEDET_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`else
    // Debounce length has no effect when the filter is compiled out.
    if (DEBOUNCE_CYCLES == 0) begin : g_debounce_unused
    end
`endif

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [SYNC_STEPS-1:0] sync_q;
        logic                  s;
        logic                  f_q;
        logic                  f_d;
        logic                  ev;
        logic                  edge_q;
        logic                  pend_q;
        logic                  pend_d;
        logic                  ovf_q;
        logic                  ovf_d;

        assign s = sync_q[SYNC_STEPS-1];

`ifdef EDGEDET_DEBOUNCE_EN
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
        always_comb begin
            f_d   = f_q;
            cnt_d = cnt_q;
            if (s == f_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                f_d   = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge in_clk or posedge in_rst) begin
            if (in_rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
`else
        assign f_d = s;
`endif

        // Edge of the filtered level, qualified by this channel's rise/fall enables.
        always_comb begin
            ev = ((f_d & ~f_q) & in_mode[2*i]) | ((~f_d & f_q) & in_mode[2*i+1]);
        end

        // Pending/overflow follow the registered pulse; an event wins over a coincident ack.
        always_comb begin
            pend_d = pend_q;
            ovf_d  = ovf_q;
            if (edge_q && in_ack[i]) begin
                pend_d = 1'b1;
                ovf_d  = 1'b0;
            end else if (edge_q && pend_q) begin
                ovf_d  = 1'b1;
            end else if (edge_q) begin
                pend_d = 1'b1;
            end else if (in_ack[i]) begin
                pend_d = 1'b0;
                ovf_d  = 1'b0;
            end
        end

        always_ff @(posedge in_clk or posedge in_rst) begin
            if (in_rst) begin
                sync_q <= '0;
                f_q    <= 1'b0;
                edge_q <= 1'b0;
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STEPS-2:0], in_signal[i]};
                f_q    <= f_d;
                edge_q <= ev;
                pend_q <= pend_d;
                ovf_q  <= ovf_d;
            end
        end

        assign out_edge[i]     = edge_q;
        assign out_pending[i]  = pend_q;
        assign out_overflow[i] = ovf_q;
    end

    assign out_any = |out_pending;

endmodule
